// File: rtl/unary_pkg.sv
// Shared types and sizing helpers for the unary-to-binary stream decoder.
package unary_pkg;

   localparam int DEF_SIZE  = 4;
   localparam int DEF_LANES = 2;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} dec_state_t;

   // Nominal frame: 2^size value slots plus two guard cycles.
   function automatic int frame_len(input int size);
      return (1 << size) + 2;
   endfunction

   function automatic int cnt_width(input int size);
      return $clog2(frame_len(size) + 1);
   endfunction

   // Result word for the default configuration.
   typedef struct packed {
      logic [DEF_LANES-1:0][DEF_SIZE-1:0] data;
      logic [DEF_LANES-1:0]               err;
      logic                               len_err;
   } decode_result_t;

endpackage

// File: rtl/unary_stream_decoder_if.sv
// Stream input and valid/ready result bus of the unary stream decoder.
interface unary_stream_decoder_if #(
   parameter int SIZE  = 4,
   parameter int LANES = 2
);
   logic                    frame_start;
   logic [LANES-1:0]        unary_in;
   logic                    out_ready;
   logic                    out_valid;
   logic [LANES*SIZE-1:0]   out_data;
   logic [LANES-1:0]        out_err;
   logic                    out_len_err;
   logic                    overrun;

   modport master (
      output frame_start, unary_in, out_ready,
      input  out_valid, out_data, out_err, out_len_err, overrun
   );

   modport slave (
      input  frame_start, unary_in, out_ready,
      output out_valid, out_data, out_err, out_len_err, overrun
   );
endinterface

// File: rtl/unary_lane_counter.sv
// One lane: counts ones in the current frame and flags thermometer violations.
module unary_lane_counter
   import unary_pkg::*;
#(
   parameter int SIZE = 4,
   parameter int CW   = 5
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            frame_start,
   input  logic            bit_in,
   output logic [SIZE-1:0] data,
   output logic            err
);

   localparam logic [CW-1:0] MAXV = CW'((1 << SIZE) - 1);

   logic [CW-1:0] cnt;
   logic          seen_zero;
   logic          viol;
   logic          over;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt       <= '0;
         seen_zero <= 1'b0;
         viol      <= 1'b0;
      end else if (frame_start) begin
         cnt       <= {{(CW-1){1'b0}}, bit_in};
         seen_zero <= ~bit_in;
         viol      <= 1'b0;
      end else begin
         if (bit_in && (cnt != '1)) cnt <= cnt + 1'b1;
         seen_zero <= seen_zero | ~bit_in;
         viol      <= viol | (seen_zero & bit_in);
      end
   end

   // Outputs reflect the frame so far; the top samples them on the closing strobe.
   always_comb begin
      over = (cnt > MAXV);
      data = over ? {SIZE{1'b1}} : cnt[SIZE-1:0];
      err  = viol | over;
   end

endmodule

// File: rtl/unary_stream_decoder.sv
// Decodes per-lane thermometer streams into binary words behind a one-entry valid/ready register.
module unary_stream_decoder
   import unary_pkg::*;
#(
   parameter int SIZE      = 4,
   parameter int LANES     = 2,
   parameter int FRAME_LEN = frame_len(SIZE),
   parameter int CW        = $clog2(FRAME_LEN + 1)
) (
   input  logic                   clk,
   input  logic                   reset_n,
   unary_stream_decoder_if.slave  bus
);

   localparam logic [CW-1:0] FL = CW'(FRAME_LEN);

   typedef struct packed {
      logic [LANES-1:0][SIZE-1:0] data;
      logic [LANES-1:0]           err;
      logic                       len_err;
   } word_t;

   dec_state_t state_q, state_d;
   logic [CW-1:0] pos_q;
   word_t         word_q, word_d, fresh;
   logic          valid_q, valid_d;
   logic          overrun_q, overrun_d;
   logic          commit;

   logic [LANES-1:0]           ubits;
   logic [LANES-1:0][SIZE-1:0] lane_data;
   logic [LANES-1:0]           lane_err;

   assign ubits = bus.unary_in;

   unary_lane_counter #(.SIZE(SIZE), .CW(CW)) u_lane [LANES-1:0] (
      .clk         (clk),
      .reset_n     (reset_n),
      .frame_start (bus.frame_start),
      .bit_in      (ubits),
      .data        (lane_data),
      .err         (lane_err)
   );

   // pos also runs while unarmed so the first closed frame is measured correctly.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)              pos_q <= '0;
      else if (bus.frame_start)  pos_q <= CW'(1);
      else if (pos_q != '1)      pos_q <= pos_q + 1'b1;
   end

   assign commit        = bus.frame_start & (state_q == RUN);
   assign fresh.data    = lane_data;
   assign fresh.err     = lane_err;
   assign fresh.len_err = (pos_q != FL);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         word_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         word_q    <= word_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      word_d    = word_q;
      valid_d   = valid_q;
      overrun_d = 1'b0;
      if (state_q == IDLE && bus.frame_start) state_d = RUN;
      if (commit) begin
         // A held, unaccepted word wins; the new result is dropped.
         if (!valid_q || bus.out_ready) begin
            word_d  = fresh;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (valid_q && bus.out_ready) begin
         valid_d = 1'b0;
      end
   end

   assign bus.out_valid   = valid_q;
   assign bus.out_data    = word_q.data;
   assign bus.out_err     = word_q.err;
   assign bus.out_len_err = word_q.len_err;
   assign bus.overrun     = overrun_q;

endmodule
